// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, slave word
// addresses and the default expected ID/timestamp values.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0001_2345;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5354_22F6;

endpackage

// File: rtl/sysid_timeout_cnt.sv
// Clearable saturating 16-bit cycle counter; flags when the count equals LIMIT
// while counting is enabled.
module sysid_timeout_cnt #(
    parameter logic [15:0] LIMIT = 16'd255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    // Gated by enable so a stale count left over in IDLE/DONE never reports.
    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave's ID and timestamp words once
// after reset and on each start pulse, and reports match and timeout status.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_chk_state_t state, state_next;
    logic auto_pend;
    logic in_flight;
    logic entering_id;
    logic entering_ts;
    logic expired;
    logic cap_id;
    logic cap_ts;
    logic timeout_fire;

    assign in_flight   = (state == ID_REQ) || (state == ID_WAIT) ||
                         (state == TS_REQ) || (state == TS_WAIT);
    assign entering_id = (state_next == ID_REQ) && (state != ID_REQ);
    assign entering_ts = (state_next == TS_REQ) && (state != TS_REQ);

    sysid_timeout_cnt #(
        .LIMIT (16'(TIMEOUT_CYCLES))
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (entering_id || entering_ts),
        .enable  (in_flight),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        avm_read     = 1'b0;
        avm_address  = SYSID_ADDR_ID;
        cap_id       = 1'b0;
        cap_ts       = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_pend) begin
                    state_next = ID_REQ;
                end
            end
            ID_REQ: begin
                avm_read = !expired;
                if (expired) begin
                    timeout_fire = 1'b1;
                    state_next   = DONE;
                end else if (!avm_waitrequest) begin
                    state_next = ID_WAIT;
                end
            end
            // Data arriving in the same cycle as expiry still counts as in time.
            ID_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_id     = 1'b1;
                    state_next = TS_REQ;
                end else if (expired) begin
                    timeout_fire = 1'b1;
                    state_next   = DONE;
                end
            end
            TS_REQ: begin
                avm_read    = !expired;
                avm_address = SYSID_ADDR_TS;
                if (expired) begin
                    timeout_fire = 1'b1;
                    state_next   = DONE;
                end else if (!avm_waitrequest) begin
                    state_next = TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_ts     = 1'b1;
                    state_next = DONE;
                end else if (expired) begin
                    timeout_fire = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = ID_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend   <= AUTO_START;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            auto_pend <= 1'b0;
            busy      <= (state_next != IDLE) && (state_next != DONE);
            done      <= (state_next == DONE);
            if (entering_id) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end else begin
                if (cap_id) begin
                    id_value <= avm_readdata;
                    id_ok    <= (avm_readdata == EXPECTED_ID);
                end
                if (cap_ts) begin
                    ts_value <= avm_readdata;
                    ts_ok    <= (avm_readdata == EXPECTED_TS);
                end
                if (timeout_fire) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule
